// File: rtl/tetris_pkg.sv
// Shared definitions for the input path and the grid controller.
//   - CMD_*   : 4-bit command codes driven on controller_out / controller_in
//   - BTN_*   : bit positions of the buttons in the 8-bit pad frame
//   - S_*     : pad protocol FSM state encodings
//   - decode_buttons / is_repeatable : command priority and repeat class
package tetris_pkg;

  localparam logic [3:0] CMD_NONE    = 4'b0000;
  localparam logic [3:0] CMD_LEFT    = 4'b0001;
  localparam logic [3:0] CMD_RIGHT   = 4'b0010;
  localparam logic [3:0] CMD_DOWN    = 4'b0011;
  localparam logic [3:0] CMD_START   = 4'b0100;
  localparam logic [3:0] CMD_ROT_CW  = 4'b0101;
  localparam logic [3:0] CMD_ROT_CCW = 4'b0110;
  localparam logic [3:0] CMD_DROP    = 4'b0111;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_CLK_LO = 3'd3;
  localparam logic [2:0] S_CLK_HI = 3'd4;
  localparam logic [2:0] S_DECODE = 3'd5;

  // Highest-priority command present in an active-high button frame.
  // Select never contributes; Left+Right together cancel and fall through.
  function automatic logic [3:0] decode_buttons(input logic [7:0] b);
    logic [3:0] c;
    c = CMD_NONE;
    if (b[BTN_START])                      c = CMD_START;
    else if (b[BTN_UP])                    c = CMD_DROP;
    else if (b[BTN_A])                     c = CMD_ROT_CW;
    else if (b[BTN_B])                     c = CMD_ROT_CCW;
    else if (b[BTN_LEFT] && !b[BTN_RIGHT]) c = CMD_LEFT;
    else if (b[BTN_RIGHT] && !b[BTN_LEFT]) c = CMD_RIGHT;
    else if (b[BTN_DOWN])                  c = CMD_DOWN;
    return c;
  endfunction

  function automatic logic is_repeatable(input logic [3:0] c);
    return (c == CMD_LEFT) || (c == CMD_RIGHT) || (c == CMD_DOWN);
  endfunction

endpackage

// File: rtl/nes_pad_shifter.sv
// NES pad protocol engine: periodic latch/clock/sample of the 8 serial
// buttons.
//   clk, reset        : system clock, async active-high reset
//   pad_data          : serial data from pad (active-low, async to clk)
//   pad_latch         : parallel-load strobe to pad
//   pad_clk           : shift clock to pad, idles high
//   frame[7:0]        : active-high button frame, valid while frame_done
//   frame_done        : one-cycle pulse once all 8 bits are captured
module nes_pad_shifter
  import tetris_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 300,
  parameter int unsigned POLL_INTERVAL = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] frame,
  output logic       frame_done
);

  localparam int TW = $clog2(POLL_INTERVAL);
  localparam int DW = $clog2(CLK_DIV);

  logic          sync1_q, sync2_q;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          pad_latch_q, pad_latch_d;
  // Stored inverted so that every register clears to 0 on reset while
  // pad_clk still idles high.
  logic          pad_clk_lo_q, pad_clk_lo_d;
  logic          poll_start, phase_end;

  assign poll_start = (timer_q == TW'(POLL_INTERVAL - 1));
  assign phase_end  = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    // Timer free-runs in every state so poll starts are strictly periodic.
    timer_d   = poll_start ? '0 : timer_q + TW'(1);
    state_d   = state_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (poll_start) begin
          state_d   = S_LATCH;
          div_d     = '0;
          bit_cnt_d = '0;
        end
      end
      S_LATCH: begin
        if (phase_end) begin
          state_d = S_SAMPLE;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_SAMPLE: begin
        shreg_d[bit_cnt_q] = ~sync2_q;
        state_d            = (bit_cnt_q == 3'd7) ? S_DECODE : S_CLK_LO;
      end
      S_CLK_LO: begin
        if (phase_end) begin
          state_d = S_CLK_HI;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_CLK_HI: begin
        if (phase_end) begin
          state_d   = S_SAMPLE;
          div_d     = '0;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_DECODE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Pad pins are registered from the next state so they line up with
    // state_q exactly and never glitch.
    pad_latch_d  = (state_d == S_LATCH);
    pad_clk_lo_d = (state_d == S_CLK_LO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      state_q      <= S_IDLE;
      timer_q      <= '0;
      div_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      pad_latch_q  <= 1'b0;
      pad_clk_lo_q <= 1'b0;
    end else begin
      sync1_q      <= pad_data;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      timer_q      <= timer_d;
      div_q        <= div_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      pad_latch_q  <= pad_latch_d;
      pad_clk_lo_q <= pad_clk_lo_d;
    end
  end

  assign pad_latch  = pad_latch_q;
  assign pad_clk    = ~pad_clk_lo_q;
  assign frame      = shreg_q;
  assign frame_done = (state_q == S_DECODE);

endmodule

// File: rtl/input_controller.sv
// Gamepad front end for the grid controller: polls the pad, reduces the
// buttons to one prioritised command and applies auto-repeat.
//   clk, reset          : system clock, async active-high reset
//   pad_data            : serial pad data (active-low, async)
//   pad_latch, pad_clk  : pad protocol outputs
//   controller_out[3:0] : command code (CMD_*), held between polls
//   cmd_valid           : one-cycle pulse for each newly emitted command
//   buttons[7:0]        : last captured frame, active-high
module input_controller
  import tetris_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 300,
  parameter int unsigned POLL_INTERVAL = 833333,
  parameter int unsigned REPEAT_DELAY  = 10,
  parameter int unsigned REPEAT_RATE   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [3:0] controller_out,
  output logic       cmd_valid,
  output logic [7:0] buttons
);

  logic [7:0] frame;
  logic       frame_done;

  nes_pad_shifter #(
    .CLK_DIV      (CLK_DIV),
    .POLL_INTERVAL(POLL_INTERVAL)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .frame     (frame),
    .frame_done(frame_done)
  );

  logic [3:0] out_q, out_d;
  logic       vld_q, vld_d;
  logic [7:0] btn_q, btn_d;
  logic [3:0] prev_q, prev_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] rate_q, rate_d;
  logic [3:0] code;
  logic [7:0] rate_inc;
  logic       emit;

  assign code     = decode_buttons(frame);
  assign rate_inc = rate_q + 8'd1;

  always_comb begin
    out_d  = out_q;
    vld_d  = 1'b0;
    btn_d  = btn_q;
    prev_d = prev_q;
    hold_d = hold_q;
    rate_d = rate_q;
    emit   = 1'b0;
    if (frame_done) begin
      btn_d  = frame;
      prev_d = code;
      if (code == CMD_NONE) begin
        hold_d = '0;
        rate_d = '0;
      end else if (code != prev_q) begin
        emit   = 1'b1;
        hold_d = '0;
        rate_d = '0;
      end else begin
        hold_d = (hold_q == 8'hFF) ? 8'hFF : hold_q + 8'd1;
        if (hold_q < 8'(REPEAT_DELAY)) begin
          // First repeat fires on the poll where hold reaches the delay.
          emit = is_repeatable(code) && (hold_d == 8'(REPEAT_DELAY));
        end else if (rate_inc == 8'(REPEAT_RATE)) begin
          emit   = is_repeatable(code);
          rate_d = '0;
        end else begin
          rate_d = rate_inc;
        end
      end
      out_d = emit ? code : CMD_NONE;
      vld_d = emit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= CMD_NONE;
      vld_q  <= 1'b0;
      btn_q  <= '0;
      prev_q <= CMD_NONE;
      hold_q <= '0;
      rate_q <= '0;
    end else begin
      out_q  <= out_d;
      vld_q  <= vld_d;
      btn_q  <= btn_d;
      prev_q <= prev_d;
      hold_q <= hold_d;
      rate_q <= rate_d;
    end
  end

  assign controller_out = out_q;
  assign cmd_valid      = vld_q;
  assign buttons        = btn_q;

endmodule

// File: tb/tb_input_controller.sv
module tb_input_controller;

  localparam int D     = 4;
  localparam int PI    = 100;
  localparam int DELAY = 2;
  localparam int RATE  = 2;
  localparam int LAT   = 15 * D + 9;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pad_data;
  logic       pad_latch, pad_clk, cmd_valid;
  logic [3:0] controller_out;
  logic [7:0] buttons;

  input_controller #(
    .CLK_DIV(D), .POLL_INTERVAL(PI), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .reset(reset), .pad_data(pad_data), .pad_latch(pad_latch),
    .pad_clk(pad_clk), .controller_out(controller_out), .cmd_valid(cmd_valid),
    .buttons(buttons)
  );

  always #5 clk = ~clk;

  // Pad model: parallel load while latched, advance one button per pad_clk rise.
  logic [7:0] pad_frame = 8'h00;
  int         pad_idx = 0;
  always @(posedge pad_latch or posedge pad_clk)
    if (pad_latch) pad_idx <= 0;
    else           pad_idx <= pad_idx + 1;
  assign pad_data = (pad_idx < 8) ? ~pad_frame[pad_idx[2:0]] : 1'b0;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: command priority and run-length repeat rule.
  function automatic int model_code(input logic [7:0] f);
    if (f[3]) return 4;
    if (f[4]) return 7;
    if (f[0]) return 5;
    if (f[1]) return 6;
    if (f[6] != f[7]) return f[6] ? 1 : 2;
    if (f[5]) return 3;
    return 0;
  endfunction

  int         cyc = -1;
  int         run_code = 0, run_len = 0;
  int         exp_out = 0, exp_vld = 0, exp_btn = 0;
  logic [7:0] snap = 8'h00;
  int         latch_cyc = 0, clk_lo_pulses = 0, vcount = 0, last_vld_off = -1;
  logic       prev_clk = 1'b1;

  task automatic model_poll(input logic [7:0] f);
    int c, k;
    c       = model_code(f);
    exp_btn = int'(f);
    exp_vld = 0;
    if (c == 0) begin
      run_len = 0;
    end else if (run_len > 0 && c == run_code) begin
      run_len++;
      k = run_len - 1;
      if ((c >= 1 && c <= 3) && k >= DELAY && ((k - DELAY) % RATE) == 0) exp_vld = 1;
    end else begin
      run_len = 1;
      exp_vld = 1;
    end
    run_code = c;
    exp_out  = exp_vld ? c : 0;
  endtask

  // Per-cycle compare: cyc counts rising edges since reset release.
  always @(negedge clk) begin
    int o, exp_latch, exp_clk;
    exp_latch = 0;
    exp_clk   = 1;
    if (reset) begin
      cyc = -1; run_len = 0; run_code = 0;
      exp_out = 0; exp_vld = 0; exp_btn = 0;
    end else begin
      cyc++;
      exp_vld = 0;
      if (cyc >= PI) begin
        o = cyc % PI;
        if (o == 0) begin
          snap = pad_frame; latch_cyc = 0; clk_lo_pulses = 0;
        end
        if (o == LAT) model_poll(snap);
        exp_latch = (o < D) ? 1 : 0;
        for (int k = 0; k < 7; k++)
          if (o >= D + 1 + k * (2 * D + 1) && o < 2 * D + 1 + k * (2 * D + 1)) exp_clk = 0;
      end
    end
    chk("pad_latch", int'(pad_latch), exp_latch);
    chk("pad_clk", int'(pad_clk), exp_clk);
    chk("controller_out", int'(controller_out), exp_out);
    chk("cmd_valid", int'(cmd_valid), exp_vld);
    chk("buttons", int'(buttons), exp_btn);
    if (!reset) begin
      if (pad_latch) latch_cyc++;
      if (prev_clk && !pad_clk) clk_lo_pulses++;
      if (cmd_valid) begin
        vcount++;
        last_vld_off = cyc % PI;
      end
    end
    prev_clk = pad_clk;
  end

  // Advance to the quiet point of the next poll (well after its decode).
  task automatic wait_poll();
    int b;
    b = 0;
    @(posedge clk);
    while (!(cyc >= PI && cyc % PI == 80)) begin
      @(posedge clk);
      b++;
      if (b > 3 * PI) begin
        chk("poll_timeout", 1, 0);
        return;
      end
    end
    #1;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_latch"}, int'(pad_latch), 0);
    chk({tag, "_clk"}, int'(pad_clk), 1);
    chk({tag, "_out"}, int'(controller_out), 0);
    chk({tag, "_vld"}, int'(cmd_valid), 0);
    chk({tag, "_btn"}, int'(buttons), 0);
  endtask

  initial begin
    int v0, b;
    logic [7:0] pat;
    repeat (3) @(posedge clk);
    #1 reset_vals("rst");
    reset = 1'b0;

    // Idle pad: nothing emitted over five polls.
    v0 = vcount;
    repeat (5) wait_poll();
    chk("idle_emits", vcount - v0, 0);

    // A alone: protocol shape, latency and code.
    pad_frame = 8'h01;
    v0 = vcount;
    wait_poll();
    chk("latch_cycles", latch_cyc, 4);
    chk("clk_lo_pulses", clk_lo_pulses, 7);
    chk("latency", last_vld_off, 69);
    chk("a_emits", vcount - v0, 1);
    chk("a_out", int'(controller_out), 5);
    chk("a_btn", int'(buttons), 8'h01);
    pad_frame = 8'h00;
    wait_poll();

    // Left held eight polls: emits on 1, 3, 5, 7.
    pad_frame = 8'h40;
    pat = 8'h00;
    for (int i = 0; i < 8; i++) begin
      v0 = vcount;
      wait_poll();
      pat[i] = (vcount != v0);
      chk("left_out", int'(controller_out), (i % 2 == 0) ? 1 : 0);
    end
    chk("left_pattern", int'(pat), 8'h55);
    pad_frame = 8'h00;
    wait_poll();

    // Start+Left+A held: START once, never repeats.
    pad_frame = 8'h49;
    v0 = vcount;
    for (int i = 0; i < 6; i++) begin
      wait_poll();
      if (i == 0) chk("start_out", int'(controller_out), 4);
    end
    chk("start_emits", vcount - v0, 1);
    chk("start_out_held", int'(controller_out), 0);
    pad_frame = 8'h00;
    wait_poll();

    // Left+Right cancel: falls through to Down, or to nothing.
    pad_frame = 8'hE0;
    wait_poll();
    chk("lrd_out", int'(controller_out), 3);
    pad_frame = 8'hC0;
    v0 = vcount;
    wait_poll();
    chk("lr_out", int'(controller_out), 0);
    chk("lr_emits", vcount - v0, 0);

    // Reset during bit-3 clock-low phase.
    pad_frame = 8'h80;
    wait_poll();
    chk("right_out", int'(controller_out), 2);
    b = 0;
    while (!(cyc >= PI && cyc % PI == 33) && b < 3 * PI) begin
      @(posedge clk);
      b++;
    end
    chk("reach_clk_lo", (cyc >= PI && cyc % PI == 33) ? 1 : 0, 1);
    #1 chk("pre_rst_clk", int'(pad_clk), 0);
    reset = 1'b1;
    #1 reset_vals("midrst");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    v0 = vcount;
    b = 0;
    while (cyc != PI + LAT - 1 && b < 3 * PI) begin
      @(posedge clk);
      b++;
    end
    chk("no_early_emit", vcount - v0, 0);
    wait_poll();
    chk("post_rst_emits", vcount - v0, 1);
    chk("post_rst_out", int'(controller_out), 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_err);
    $fatal(1, "watchdog");
  end

endmodule
